// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap entry and MRET sequencer; sole driver of csr_file trap/mret strobes.
// Optional WFI sleep support is compiled in when TRAP_WFI_EN is defined.
module trap_controller #(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_mstatus_mie,
    input  logic [XLEN-1:0] i_mie,
    input  logic [2:0]      i_interrupts,      // packed as {meip, mtip, msip}
    input  logic [XLEN-1:0] i_mtvec,
    input  logic [XLEN-1:0] i_mepc,
    input  logic            i_exception_valid,
    input  logic [XLEN-1:0] i_exception_cause,
    input  logic [XLEN-1:0] i_exception_pc,
    input  logic [XLEN-1:0] i_exception_tval,
    input  logic            i_mret,
    input  logic            i_wfi,
    input  logic            i_pipeline_idle,
    input  logic [XLEN-1:0] i_resume_pc,
    output logic            o_stall,
    output logic            o_flush,
    output logic            o_redirect_valid,
    output logic [XLEN-1:0] o_redirect_pc,
    output logic            o_trap_taken,
    output logic [XLEN-1:0] o_trap_pc,
    output logic [XLEN-1:0] o_trap_cause,
    output logic [XLEN-1:0] o_trap_value,
    output logic            o_mret_taken,
    output logic            o_wfi_sleep
);

    // state   | meaning
    // IDLE    | normal execution, arbitrate exception > MRET > interrupt > WFI
    // DRAIN   | fetch stalled, waiting for in-flight instructions to retire
    // TRAP    | one-cycle trap-entry strobe, flush and redirect to mtvec
    // MRET    | one-cycle MRET strobe, flush and redirect to mepc
    // SLEEP   | WFI sleep until any locally enabled interrupt is pending
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAIN = 3'd1,
        S_TRAP  = 3'd2,
        S_MRET  = 3'd3,
        S_SLEEP = 3'd4
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] trap_pc_q, trap_pc_d;
    logic [XLEN-1:0] trap_cause_q, trap_cause_d;
    logic [XLEN-1:0] trap_value_q, trap_value_d;

    logic [XLEN-1:0] mip;
    logic [XLEN-1:0] pend;
    logic            irq_any;
    logic            irq_req;
    logic [3:0]      irq_code;
    logic [XLEN-1:0] irq_cause;

    always_comb begin
        mip     = '0;
        mip[3]  = i_interrupts[0];
        mip[7]  = i_interrupts[1];
        mip[11] = i_interrupts[2];
    end

    assign pend    = mip & i_mie;
    assign irq_any = |pend;
    assign irq_req = i_mstatus_mie & irq_any;

    // MSI deliberately outranks MTI even though its code is lower.
    always_comb begin
        if (pend[11]) begin
            irq_code = 4'd11;
        end else if (pend[3]) begin
            irq_code = 4'd3;
        end else begin
            irq_code = 4'd7;
        end
    end

    assign irq_cause = {1'b1, {(XLEN-5){1'b0}}, irq_code};

`ifdef TRAP_WFI_EN
    logic unused_ok;
    assign unused_ok = ^i_mtvec[1:0];
`else
    logic unused_ok;
    assign unused_ok = ^{i_mtvec[1:0], i_wfi};
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            trap_pc_q    <= '0;
            trap_cause_q <= '0;
            trap_value_q <= '0;
        end else begin
            state_q      <= state_d;
            trap_pc_q    <= trap_pc_d;
            trap_cause_q <= trap_cause_d;
            trap_value_q <= trap_value_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        trap_pc_d    = trap_pc_q;
        trap_cause_d = trap_cause_q;
        trap_value_d = trap_value_q;
        case (state_q)
            S_IDLE: begin
                if (i_exception_valid) begin
                    trap_pc_d    = i_exception_pc;
                    trap_cause_d = i_exception_cause;
                    trap_value_d = i_exception_tval;
                    state_d      = S_TRAP;
                end else if (i_mret) begin
                    state_d = S_MRET;
                end else if (irq_req) begin
                    state_d = S_DRAIN;
                end
`ifdef TRAP_WFI_EN
                else if (i_wfi) begin
                    state_d = S_SLEEP;
                end
`endif
            end
            S_DRAIN: begin
                // A draining instruction's exception wins; the interrupt is retaken afterwards.
                if (i_exception_valid) begin
                    trap_pc_d    = i_exception_pc;
                    trap_cause_d = i_exception_cause;
                    trap_value_d = i_exception_tval;
                    state_d      = S_TRAP;
                end else if (!irq_req) begin
                    state_d = S_IDLE;
                end else if (i_pipeline_idle) begin
                    trap_pc_d    = i_resume_pc;
                    trap_cause_d = irq_cause;
                    trap_value_d = '0;
                    state_d      = S_TRAP;
                end
            end
            S_TRAP:  state_d = S_IDLE;
            S_MRET:  state_d = S_IDLE;
            S_SLEEP: begin
                // Wake ignores global MIE; without it the WFI simply retires as a NOP.
                if (irq_any) begin
                    state_d = irq_req ? S_DRAIN : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_stall          = 1'b0;
        o_flush          = 1'b0;
        o_redirect_valid = 1'b0;
        o_redirect_pc    = '0;
        o_trap_taken     = 1'b0;
        o_mret_taken     = 1'b0;
        o_wfi_sleep      = 1'b0;
        if (!i_rst) begin
            case (state_q)
                S_IDLE: begin
                    o_stall = irq_req & ~i_exception_valid & ~i_mret;
                end
                S_DRAIN: begin
                    o_stall = 1'b1;
                end
                S_TRAP: begin
                    o_trap_taken     = 1'b1;
                    o_flush          = 1'b1;
                    o_redirect_valid = 1'b1;
                    o_redirect_pc    = {i_mtvec[XLEN-1:2], 2'b00};
                end
                S_MRET: begin
                    o_mret_taken     = 1'b1;
                    o_flush          = 1'b1;
                    o_redirect_valid = 1'b1;
                    o_redirect_pc    = i_mepc;
                end
                S_SLEEP: begin
                    o_stall = 1'b1;
`ifdef TRAP_WFI_EN
                    o_wfi_sleep = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign o_trap_pc    = trap_pc_q;
    assign o_trap_cause = trap_cause_q;
    assign o_trap_value = trap_value_q;

endmodule
